vga_rect_fill: RTL and testbench
================================

# vga_rect_fill

Bus initiator that fills an axis-aligned rectangle of the 160x120 one-bit frame buffer by issuing write cycles to the VGA peripheral's register bank. It sits beside the microprocessor on the shared 8-bit bus, requests ownership through a REQ/GNT handshake, and offloads pixel-by-pixel drawing from software. It generates exactly the register writes the VGA peripheral expects: colour, X address, then Y address with the write-enable bit set and cleared.

## Interface
- BASE_ADDR, 8'hB0: bus address of the VGA register 0 (X). Register 1 (Y, bit 7 = WE) is at BASE_ADDR+1. Register 2 (colour bit 0, trigger bit 1) is at BASE_ADDR+2.
- X_MAX, 159: largest legal X coordinate.
- Y_MAX, 119: largest legal Y coordinate.

Ports:
- CLK  in  1  single system clock; all logic on rising edge.
- RESET  in  1  synchronous, active-high reset.
- START  in  1  one-cycle command strobe; sampled only in IDLE.
- X0, X1  in  8 each  rectangle X corners, inclusive.
- Y0, Y1  in  7 each  rectangle Y corners, inclusive.
- COLOUR  in  1  pixel value to write.
- BUSY  out  1  high from the cycle after an accepted START until DONE.
- DONE  out  1  one-cycle pulse when the final bus write completes.
- BUS_REQ  out  1  bus ownership request.
- BUS_GNT  in  1  bus grant from the arbiter.
- BUS_ADDR  out  8  bus address; 8'h00 when not driving.
- BUS_DATA  inout  8  driven only while BUS_WE=1, otherwise high-Z.
- BUS_WE  out  1  bus write strobe.

## Operation
- Reset values: BUSY=0, DONE=0, BUS_REQ=0, BUS_WE=0, BUS_ADDR=8'h00, BUS_DATA high-Z, FSM=IDLE.
- START in IDLE latches the corners, ordered so xl=min(X0,X1), xh=max, yl, yh likewise. Each coordinate is clamped to X_MAX/Y_MAX. COLOUR is also latched. START outside IDLE is ignored.
- FSM states:
  - IDLE: on START, go to REQ.
  - REQ: BUS_REQ=1. On BUS_GNT=1, go to COL.
  - COL: write BASE_ADDR+2 <= {7'b0,colour}. The trigger bit is always 0. Go to SETX.
  - SETX: write BASE_ADDR <= x. Go to SETY.
  - SETY: write BASE_ADDR+1 <= {1'b1,y}. Go to CLRY.
  - CLRY: write BASE_ADDR+1 <= {1'b0,y}. The frame buffer stores the pixel during this cycle. Advance x. When x=xh, set x=xl and advance y. When y=yh and x=xh, go to FIN. Otherwise go to SETX, or to STALL if BUS_GNT=0.
  - STALL: bus outputs released, BUS_REQ=1. On BUS_GNT=1, go to SETX.
  - FIN: DONE=1, BUS_REQ=0, bus released. Go to IDLE.
- The SETX/SETY/CLRY triple is atomic: BUS_GNT is ignored inside it, so the WE bit is never left set. BUS_GNT is checked only on entry to COL and after CLRY.
- Counters: x is 8 bits and y is 7 bits. Scan order is row-major, x fastest. There is no wrap beyond the clamped limits.
- Reset mid-operation returns to IDLE in one cycle with bus released. No DONE pulse is issued.

## Timing
- Bus outputs are registered. BUS_WE, BUS_ADDR and BUS_DATA are valid for the whole cycle the FSM spends in COL, SETX, SETY or CLRY.
- START at cycle 0 gives BUSY=1 and BUS_REQ=1 at cycle 1.
- If BUS_GNT=1 is already high at cycle 1, COL occupies cycle 2 and the first SETX occupies cycle 3.
- Uninterrupted fill of N pixels: 1 + 3N write cycles, then FIN. DONE is high in the cycle after the last CLRY. BUSY falls in the same cycle DONE rises.
- A stall inserts at least 1 cycle per GNT drop. The resume goes to SETX at the next pixel; no pixel is repeated or skipped.

## Test plan
- **Single pixel.** START with X0=X1=5, Y0=Y1=3, COLOUR=1, GNT tied high.
  - Bus writes in order: B2<=01, B0<=05, B1<=83, B1<=03.
  - DONE pulses exactly 5 cycles after BUS_REQ rises.
  - Frame buffer address 0x0305 reads 1.
- **Rectangle with swapped corners.** X0=11, X1=10, Y0=21, Y1=20.
  - Pixels are written in order (10,20), (11,20), (10,21), (11,21).
  - 13 write cycles in total; a frame-buffer model shows exactly those 4 bits set.
- **Clamping.** X1=200, Y1=127, X0=158, Y0=118.
  - Writes cover x 158..159 and y 118..119 only: 4 pixels.
  - No BUS_ADDR write with data above 159 at B0 or Y above 119 at B1.
- **Grant drop.** During a 3x1 fill, drop GNT while in SETY of pixel 1.
  - The triple completes and the FSM enters STALL with BUS_WE=0 and BUS_DATA high-Z.
  - Re-granting resumes at SETX with x=xl+1; all 3 pixels are written once.
- **Reset mid-fill.** Assert RESET during a 4x4 fill.
  - Next cycle: BUS_REQ=0, BUS_WE=0, BUSY=0, no DONE.
  - A following 1-pixel START completes normally.
- **START while busy.** Pulse START with new corners mid-fill.
  - The current fill completes unchanged and the new corners are ignored.

Source files
------------

// File: rtl/vga_rect_fill.sv
// Bus initiator that fills a clamped, corner-ordered rectangle of the VGA
// frame buffer by issuing colour / X / Y(WE set) / Y(WE clear) register writes.
module vga_rect_fill #(
  parameter logic [7:0] BASE_ADDR = 8'hB0,
  parameter logic [7:0] X_MAX     = 8'd159,
  parameter logic [6:0] Y_MAX     = 7'd119
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] x0_i,
  input  logic [7:0] x1_i,
  input  logic [6:0] y0_i,
  input  logic [6:0] y1_i,
  input  logic       colour_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       bus_req_o,
  input  logic       bus_gnt_i,
  output logic [7:0] bus_addr_o,
  inout  wire  [7:0] bus_data_io,
  output logic       bus_we_o
);

  typedef enum logic [2:0] {
    IDLE, REQ, COL, SETX, SETY, CLRY, STALL, FIN
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] x_q, x_d, xl_q, xl_d, xh_q, xh_d;
  logic [6:0] y_q, y_d, yl_q, yl_d, yh_q, yh_d;
  logic       colour_q, colour_d;
  logic       active_q, active_d;
  logic       done_q, done_d;
  logic       we_q, we_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] dout_q, dout_d;

  logic [7:0] cx0, cx1;
  logic [6:0] cy0, cy1;

  assign cx0 = (x0_i > X_MAX) ? X_MAX : x0_i;
  assign cx1 = (x1_i > X_MAX) ? X_MAX : x1_i;
  assign cy0 = (y0_i > Y_MAX) ? Y_MAX : y0_i;
  assign cy1 = (y1_i > Y_MAX) ? Y_MAX : y1_i;

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    xl_d     = xl_q;
    xh_d     = xh_q;
    yl_d     = yl_q;
    yh_d     = yh_q;
    colour_d = colour_q;

    case (state_q)
      IDLE: if (start_i) begin
        xl_d     = (cx0 < cx1) ? cx0 : cx1;
        xh_d     = (cx0 < cx1) ? cx1 : cx0;
        yl_d     = (cy0 < cy1) ? cy0 : cy1;
        yh_d     = (cy0 < cy1) ? cy1 : cy0;
        x_d      = xl_d;
        y_d      = yl_d;
        colour_d = colour_i;
        state_d  = REQ;
      end
      REQ:  if (bus_gnt_i) state_d = COL;
      COL:  state_d = SETX;
      SETX: state_d = SETY;
      SETY: state_d = CLRY;
      // Grant is only honoured here, so a WE-set write is always followed by its clear.
      CLRY: begin
        if (x_q == xh_q && y_q == yh_q) begin
          state_d = FIN;
        end else begin
          if (x_q == xh_q) begin
            x_d = xl_q;
            y_d = y_q + 7'd1;
          end else begin
            x_d = x_q + 8'd1;
          end
          state_d = bus_gnt_i ? SETX : STALL;
        end
      end
      STALL: if (bus_gnt_i) state_d = SETX;
      FIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered bus matches the FSM cycle.
    we_d   = 1'b0;
    addr_d = 8'h00;
    dout_d = 8'h00;
    case (state_d)
      COL:  begin we_d = 1'b1; addr_d = BASE_ADDR + 8'd2; dout_d = {7'b0, colour_d}; end
      SETX: begin we_d = 1'b1; addr_d = BASE_ADDR;        dout_d = x_d;              end
      SETY: begin we_d = 1'b1; addr_d = BASE_ADDR + 8'd1; dout_d = {1'b1, y_d};      end
      CLRY: begin we_d = 1'b1; addr_d = BASE_ADDR + 8'd1; dout_d = {1'b0, y_d};      end
      default: ;
    endcase
    active_d = (state_d != IDLE) && (state_d != FIN);
    done_d   = (state_d == FIN);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      x_q      <= 8'h00;
      y_q      <= 7'h00;
      xl_q     <= 8'h00;
      xh_q     <= 8'h00;
      yl_q     <= 7'h00;
      yh_q     <= 7'h00;
      colour_q <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= 8'h00;
      dout_q   <= 8'h00;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      xl_q     <= xl_d;
      xh_q     <= xh_d;
      yl_q     <= yl_d;
      yh_q     <= yh_d;
      colour_q <= colour_d;
      active_q <= active_d;
      done_q   <= done_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      dout_q   <= dout_d;
    end
  end

  assign busy_o      = active_q;
  assign bus_req_o   = active_q;
  assign done_o      = done_q;
  assign bus_we_o    = we_q;
  assign bus_addr_o  = addr_q;
  assign bus_data_io = we_q ? dout_q : 8'bz;

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: an expected-write queue and a decoded
// frame-buffer model are checked against the bus on every falling edge.
module tb_vga_rect_fill;

  logic       clk = 1'b0;
  logic       reset, start, colour, gnt;
  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  wire        busy, done, bus_req, bus_we;
  wire  [7:0] bus_addr;
  wire  [7:0] bus_data;

  vga_rect_fill dut (
    .clk_i(clk), .reset_i(reset), .start_i(start),
    .x0_i(x0), .x1_i(x1), .y0_i(y0), .y1_i(y1), .colour_i(colour),
    .busy_o(busy), .done_o(done), .bus_req_o(bus_req), .bus_gnt_i(gnt),
    .bus_addr_o(bus_addr), .bus_data_io(bus_data), .bus_we_o(bus_we)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc_cnt = 0;
  int t0 = 0;
  bit chk_en = 1'b0;

  logic [15:0] exp_q[$];
  logic [15:0] exp_w;
  logic        fb [0:119][0:159];
  logic [7:0]  xr;
  logic [6:0]  yr;
  logic        colr = 1'b0;
  bit          armed = 1'b0;
  int          max_x_seen = 0;
  int          max_y_seen = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc_cnt - t0);
    end
  endtask

  function automatic int cl(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int mx(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Expected bus traffic: colour, then X / Y|80 / Y per pixel in row-major order.
  task automatic push_rect(input int ax0, input int ax1, input int ay0, input int ay1, input bit col);
    int xl, xh, yl, yh;
    xl = mn(cl(ax0, 159), cl(ax1, 159));
    xh = mx(cl(ax0, 159), cl(ax1, 159));
    yl = mn(cl(ay0, 119), cl(ay1, 119));
    yh = mx(cl(ay0, 119), cl(ay1, 119));
    exp_q.push_back({8'hB2, 7'b0, col});
    for (int y = yl; y <= yh; y++)
      for (int x = xl; x <= xh; x++) begin
        exp_q.push_back({8'hB0, 8'(x)});
        exp_q.push_back({8'hB1, 8'(8'h80 | y)});
        exp_q.push_back({8'hB1, 8'(y)});
      end
  endtask

  task automatic fb_clear();
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++) fb[y][x] = 1'b0;
  endtask

  task automatic fb_check(input int ax0, input int ax1, input int ay0, input int ay1);
    int xl, xh, yl, yh, bad;
    xl = mn(cl(ax0, 159), cl(ax1, 159));
    xh = mx(cl(ax0, 159), cl(ax1, 159));
    yl = mn(cl(ay0, 119), cl(ay1, 119));
    yh = mx(cl(ay0, 119), cl(ay1, 119));
    bad = 0;
    for (int y = 0; y < 120; y++)
      for (int x = 0; x < 160; x++)
        if (fb[y][x] !== ((x >= xl && x <= xh && y >= yl && y <= yh) ? 1'b1 : 1'b0)) bad++;
    check("fb_rect_bad_pixels", bad, 0);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      if (bus_we) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write_queue_len", 0, 1);
        end else begin
          exp_w = exp_q.pop_front();
          check("bus_write_addr_data", {16'h0, bus_addr, bus_data}, {16'h0, exp_w});
        end
        case (bus_addr)
          8'hB0: begin xr = bus_data; if (int'(bus_data) > max_x_seen) max_x_seen = int'(bus_data); end
          8'hB1: begin
            if (int'(bus_data[6:0]) > max_y_seen) max_y_seen = int'(bus_data[6:0]);
            if (bus_data[7]) begin
              armed = 1'b1;
              yr = bus_data[6:0];
            end else if (armed) begin
              if (yr < 7'd120 && xr < 8'd160) fb[yr][xr] = colr;
              armed = 1'b0;
            end
          end
          8'hB2: colr = bus_data[0];
          default: ;
        endcase
      end else begin
        check("idle_bus_addr", {24'h0, bus_addr}, 32'h0);
      end
    end
  end

  // Leaves the bench at cycle 1 (+1 time unit); cycle 0 is the START cycle.
  task automatic do_start(input int ax0, input int ax1, input int ay0, input int ay1, input bit col);
    @(posedge clk); #1;
    x0 = 8'(ax0); x1 = 8'(ax1); y0 = 7'(ay0); y1 = 7'(ay1); colour = col;
    start = 1'b1;
    t0 = cyc_cnt;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("busy_at_cycle1", {31'b0, busy}, 1);
    check("req_at_cycle1", {31'b0, bus_req}, 1);
  endtask

  task automatic finish_fill(input int exp_lat, input int ax0, input int ax1, input int ay0, input int ay1);
    int lat;
    bit found;
    lat = -1;
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        lat = cyc_cnt - t0;
        found = 1'b1;
        break;
      end
    end
    check("done_seen", {31'b0, found}, 1);
    check("done_latency", lat, exp_lat);
    check("busy_low_with_done", {31'b0, busy}, 0);
    check("writes_left", exp_q.size(), 0);
    fb_check(ax0, ax1, ay0, ay1);
    @(negedge clk);
    check("done_one_cycle", {31'b0, done}, 0);
    check("req_after_done", {31'b0, bus_req}, 0);
  endtask

  initial begin
    int ndone;
    reset = 1'b1; start = 1'b0; colour = 1'b0; gnt = 1'b1;
    x0 = 8'h0; x1 = 8'h0; y0 = 7'h0; y1 = 7'h0;
    fb_clear();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'b0, busy}, 0);
    check("reset_done", {31'b0, done}, 0);
    check("reset_req", {31'b0, bus_req}, 0);
    check("reset_we", {31'b0, bus_we}, 0);
    check("reset_addr", {24'b0, bus_addr}, 0);

    // Single pixel (5,3), colour 1.
    push_rect(5, 5, 3, 3, 1'b1);
    check("model_q0", {16'h0, exp_q[0]}, 32'hB201);
    check("model_q1", {16'h0, exp_q[1]}, 32'hB005);
    check("model_q2", {16'h0, exp_q[2]}, 32'hB183);
    check("model_q3", {16'h0, exp_q[3]}, 32'hB103);
    do_start(5, 5, 3, 3, 1'b1);
    finish_fill(6, 5, 5, 3, 3);
    check("fb_0305", {31'b0, fb[3][5]}, 1);

    // Swapped corners: 2x2 at (10..11, 20..21).
    fb_clear();
    push_rect(11, 10, 21, 20, 1'b1);
    check("model_swap_len", exp_q.size(), 13);
    check("model_swap_x0", {16'h0, exp_q[1]}, 32'hB00A);
    check("model_swap_y0", {16'h0, exp_q[2]}, 32'hB194);
    check("model_swap_x1", {16'h0, exp_q[4]}, 32'hB00B);
    do_start(11, 10, 21, 20, 1'b1);
    finish_fill(15, 11, 10, 21, 20);

    // Clamping to 158..159 x 118..119.
    fb_clear();
    max_x_seen = 0; max_y_seen = 0;
    push_rect(158, 200, 118, 127, 1'b1);
    check("model_clamp_len", exp_q.size(), 13);
    do_start(158, 200, 118, 127, 1'b1);
    finish_fill(15, 158, 200, 118, 127);
    check("clamp_max_x", max_x_seen, 159);
    check("clamp_max_y", max_y_seen, 119);

    // Grant drop during SETY of the second pixel of a 3x1 fill.
    fb_clear();
    push_rect(0, 2, 0, 0, 1'b1);
    do_start(0, 2, 0, 0, 1'b1);
    repeat (6) @(posedge clk);
    #1 gnt = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("stall_we", {31'b0, bus_we}, 0);
    check("stall_req", {31'b0, bus_req}, 1);
    check("stall_busy", {31'b0, busy}, 1);
    check("stall_queue_len", exp_q.size(), 3);
    @(posedge clk); #1 gnt = 1'b1;
    finish_fill(14, 0, 2, 0, 0);

    // Reset in the middle of a 4x4 fill, then a normal single pixel.
    fb_clear();
    push_rect(20, 23, 30, 33, 1'b1);
    do_start(20, 23, 30, 33, 1'b1);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    armed = 1'b0;
    @(negedge clk);
    check("midreset_req", {31'b0, bus_req}, 0);
    check("midreset_we", {31'b0, bus_we}, 0);
    check("midreset_busy", {31'b0, busy}, 0);
    check("midreset_done", {31'b0, done}, 0);
    ndone = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("no_done_after_reset", ndone, 0);
    fb_clear();
    push_rect(7, 7, 7, 7, 1'b1);
    do_start(7, 7, 7, 7, 1'b1);
    finish_fill(6, 7, 7, 7, 7);

    // START while busy is ignored.
    fb_clear();
    push_rect(40, 42, 50, 51, 1'b1);
    do_start(40, 42, 50, 51, 1'b1);
    repeat (7) @(posedge clk);
    #1;
    x0 = 8'd0; x1 = 8'd100; y0 = 7'd0; y1 = 7'd100; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    finish_fill(21, 40, 42, 50, 51);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
